// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access unit: opcodes, bus sizes, FSM states.
package mem_access_unit_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'd0;
    localparam logic [2:0] MEMOP_LBU = 3'd1;
    localparam logic [2:0] MEMOP_LH  = 3'd2;
    localparam logic [2:0] MEMOP_LHU = 3'd3;
    localparam logic [2:0] MEMOP_LW  = 3'd4;
    localparam logic [2:0] MEMOP_SB  = 3'd5;
    localparam logic [2:0] MEMOP_SH  = 3'd6;
    localparam logic [2:0] MEMOP_SW  = 3'd7;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StDone  = 3'd3,
        StDrain = 3'd4
    } state_e;

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    function automatic logic op_is_half(input logic [2:0] op);
        return (op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH);
    endfunction

    function automatic logic op_is_word(input logic [2:0] op);
        return (op == MEMOP_LW) || (op == MEMOP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [2:0] op);
        logic [1:0] sz;
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: sz = SZ_B;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: sz = SZ_H;
            default:                       sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load lane select and sign/zero extension of a raw bus word.
module mem_access_unit_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] raw_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend according to the opcode.
    always_comb begin
        unique case (addr_lo_i)
            2'd0: byte_sel = raw_i[7:0];
            2'd1: byte_sel = raw_i[15:8];
            2'd2: byte_sel = raw_i[23:16];
            2'd3: byte_sel = raw_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
        case (op_i)
            MEMOP_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_LBU: rdata_o = {24'h0, byte_sel};
            MEMOP_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
            MEMOP_LHU: rdata_o = {16'h0, half_sel};
            default:   rdata_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives one SRAM-like req/addr_ok/data_ok transaction per
// load/store, flags misaligned addresses, and stalls the pipeline until the access completes.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    input  logic        stall_ext_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        mis;
    logic        is_store;
    logic        valid;
    logic [3:0]  wstrb_new;
    logic [31:0] wdata_new;
    logic        capture;
    logic        rdata_we;
    logic [31:0] ext_data;

    // Alignment check and write-lane preparation straight from the M-stage inputs.
    always_comb begin
        is_store   = op_is_store(mem_op_i);
        mis        = (op_is_half(mem_op_i) & addr_i[0]) |
                     (op_is_word(mem_op_i) & (|addr_i[1:0]));
        adel_o     = mem_en_i & mis & ~is_store;
        ades_o     = mem_en_i & mis & is_store;
        badvaddr_o = addr_i;
        valid      = mem_en_i & ~mis & ~flush_i;

        wstrb_new = 4'b0000;
        wdata_new = wdata_i;
        case (mem_op_i)
            MEMOP_SB: begin
                wstrb_new = 4'b0001 << addr_i[1:0];
                wdata_new = {4{wdata_i[7:0]}};
            end
            MEMOP_SH: begin
                wstrb_new = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wdata_i[15:0]}};
            end
            MEMOP_SW: wstrb_new = 4'b1111;
            default:  wstrb_new = 4'b0000;
        endcase
    end

    // Transaction FSM: next state, capture enable and load-result write enable.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        rdata_we = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    capture = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        if (flush_i) begin
                            state_d = StIdle;
                        end else begin
                            state_d  = StDone;
                            rdata_we = 1'b1;
                        end
                    end else begin
                        state_d = flush_i ? StDrain : StWait;
                    end
                end else if (flush_i) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (data_data_ok) begin
                    if (flush_i) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StDone;
                        rdata_we = 1'b1;
                    end
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (data_data_ok) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (!stall_ext_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Stores complete on data_ok too, but carry no result for the register file.
        rdata_we = rdata_we & ~op_is_store(op_q);

        op_d    = capture ? mem_op_i : op_q;
        addr_d  = capture ? addr_i : addr_q;
        wstrb_d = capture ? wstrb_new : wstrb_q;
        wdata_d = capture ? wdata_new : wdata_q;
        rdata_d = rdata_we ? ext_data : rdata_q;
    end

    // Bus-facing outputs are driven only from captured state so they stay stable in REQ.
    always_comb begin
        data_req   = (state_q == StReq);
        data_wr    = op_is_store(op_q);
        data_size  = op_size(op_q);
        data_wstrb = wstrb_q;
        data_wdata = wdata_q;
        if (MAP_KSEG && (addr_q[31:30] == 2'b10)) begin
            data_addr = {3'b000, addr_q[28:0]};
        end else begin
            data_addr = addr_q;
        end
        rdata_o = rdata_q;
        // DONE is deliberately excluded so a completed access releases the pipeline.
        stall_o = (valid & ((state_q == StIdle) | (state_q == StReq) | (state_q == StWait))) |
                  (state_q == StDrain);
    end

    mem_access_unit_load_ext u_load_ext (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .raw_i     (data_rdata),
        .rdata_o   (ext_data)
    );

    // State and captured-access registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= 3'd0;
            addr_q  <= 32'h0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
